// File: rtl/core_id_ex_pkg.sv
// Shared definitions for the ID/EX stage: datapath defaults and the ALU opcode encoding.
// The opcode values are the ones the execute ALU decodes from ex_alu_ctrl.
package core_id_ex_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int REG_AW_DEF = 5;
    localparam int ALU_CTRL_W = 4;

    localparam logic [ALU_CTRL_W-1:0] ALU_ADD_OPCODE  = 4'd0;
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB_OPCODE  = 4'd1;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLL_OPCODE  = 4'd2;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT_OPCODE  = 4'd3;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLTU_OPCODE = 4'd4;
    localparam logic [ALU_CTRL_W-1:0] ALU_XOR_OPCODE  = 4'd5;
    localparam logic [ALU_CTRL_W-1:0] ALU_SRL_OPCODE  = 4'd6;
    localparam logic [ALU_CTRL_W-1:0] ALU_SRA_OPCODE  = 4'd7;
    localparam logic [ALU_CTRL_W-1:0] ALU_OR_OPCODE   = 4'd8;
    localparam logic [ALU_CTRL_W-1:0] ALU_AND_OPCODE  = 4'd9;
    localparam logic [ALU_CTRL_W-1:0] ALU_LUI_OPCODE  = 4'd10;

endpackage

// File: rtl/core_id_ex_if.sv
// Bundle of every ID-side, EX-side and bypass signal around the ID/EX stage.
// Handshake: an ID instruction moves when id_valid & id_ready; the EX entry retires when ex_valid & ex_ready.
interface core_id_ex_if
    import core_id_ex_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int REG_AW = REG_AW_DEF
);
    logic                  id_valid;
    logic                  id_ready;
    logic [ALU_CTRL_W-1:0] id_alu_ctrl;
    logic [REG_AW-1:0]     id_rs1_addr;
    logic [REG_AW-1:0]     id_rs2_addr;
    logic                  id_rs1_used;
    logic                  id_rs2_used;
    logic [XLEN-1:0]       id_rs1_data;
    logic [XLEN-1:0]       id_rs2_data;
    logic [REG_AW-1:0]     id_rd_addr;
    logic                  id_rd_wen;
    logic                  id_is_load;
    logic [XLEN-1:0]       id_imm;
    logic                  id_use_imm;
    logic [XLEN-1:0]       id_pc;
    logic                  id_use_pc;
    logic                  flush;

    logic                  ex_ready;
    logic                  ex_valid;
    logic [ALU_CTRL_W-1:0] ex_alu_ctrl;
    logic [XLEN-1:0]       ex_oprend_1;
    logic [XLEN-1:0]       ex_oprend_2;
    logic [XLEN-1:0]       ex_store_data;
    logic [REG_AW-1:0]     ex_rd_addr;
    logic                  ex_rd_wen;
    logic                  ex_is_load;
    logic [XLEN-1:0]       ex_alu_result;

    logic [REG_AW-1:0]     mem_rd_addr;
    logic                  mem_rd_wen;
    logic [XLEN-1:0]       mem_result;
    logic [REG_AW-1:0]     wb_rd_addr;
    logic                  wb_rd_wen;
    logic [XLEN-1:0]       wb_result;

    // Environment side: decoder, ALU and later pipeline stages.
    modport master (
        output id_valid, id_alu_ctrl, id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
        output id_rs1_data, id_rs2_data, id_rd_addr, id_rd_wen, id_is_load,
        output id_imm, id_use_imm, id_pc, id_use_pc, flush,
        output ex_ready, ex_alu_result,
        output mem_rd_addr, mem_rd_wen, mem_result, wb_rd_addr, wb_rd_wen, wb_result,
        input  id_ready, ex_valid, ex_alu_ctrl, ex_oprend_1, ex_oprend_2, ex_store_data,
        input  ex_rd_addr, ex_rd_wen, ex_is_load
    );

    // The ID/EX stage itself.
    modport slave (
        input  id_valid, id_alu_ctrl, id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
        input  id_rs1_data, id_rs2_data, id_rd_addr, id_rd_wen, id_is_load,
        input  id_imm, id_use_imm, id_pc, id_use_pc, flush,
        input  ex_ready, ex_alu_result,
        input  mem_rd_addr, mem_rd_wen, mem_result, wb_rd_addr, wb_rd_wen, wb_result,
        output id_ready, ex_valid, ex_alu_ctrl, ex_oprend_1, ex_oprend_2, ex_store_data,
        output ex_rd_addr, ex_rd_wen, ex_is_load
    );

endinterface

// File: rtl/core_fwd_sel.sv
// Resolves one source operand against the EX/MEM/WB writers and flags when it must stall.
// CORE_ID_EX_FORWARD_EN selects the bypass network; otherwise any pending writer stalls.
module core_fwd_sel
    import core_id_ex_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic [REG_AW-1:0] rs_addr_i,
    input  logic [XLEN-1:0]   rf_data_i,
    input  logic              ex_valid_i,
    input  logic [REG_AW-1:0] ex_rd_addr_i,
    input  logic              ex_rd_wen_i,
    input  logic              ex_is_load_i,
    input  logic [XLEN-1:0]   ex_result_i,
    input  logic [REG_AW-1:0] mem_rd_addr_i,
    input  logic              mem_rd_wen_i,
    input  logic [XLEN-1:0]   mem_result_i,
    input  logic [REG_AW-1:0] wb_rd_addr_i,
    input  logic              wb_rd_wen_i,
    input  logic [XLEN-1:0]   wb_result_i,
    output logic [XLEN-1:0]   data_o,
    output logic              stall_o
);
    logic nonzero;
    logic ex_hit;
    logic mem_hit;
    logic wb_hit;

    assign nonzero = (rs_addr_i != '0);
    assign ex_hit  = nonzero && ex_valid_i && ex_rd_wen_i && (ex_rd_addr_i == rs_addr_i);
    assign mem_hit = nonzero && mem_rd_wen_i && (mem_rd_addr_i == rs_addr_i);
    assign wb_hit  = nonzero && wb_rd_wen_i && (wb_rd_addr_i == rs_addr_i);

`ifdef CORE_ID_EX_FORWARD_EN
    // Youngest producer wins; a load in EX has no data yet, so it stalls instead.
    always_comb begin
        data_o = rf_data_i;
        if (!nonzero) begin
            data_o = '0;
        end else if (ex_hit && !ex_is_load_i) begin
            data_o = ex_result_i;
        end else if (mem_hit) begin
            data_o = mem_result_i;
        end else if (wb_hit) begin
            data_o = wb_result_i;
        end
    end

    assign stall_o = ex_hit && ex_is_load_i;
`else
    assign data_o  = nonzero ? rf_data_i : '0;
    assign stall_o = ex_hit || mem_hit || wb_hit;

    logic unused_fwd;
    assign unused_fwd = ^{ex_is_load_i, ex_result_i, mem_result_i, wb_result_i};
`endif

endmodule

// File: rtl/core_id_ex.sv
// ID/EX pipeline register: resolves operands, inserts load-use bubbles, registers ALU inputs.
// Build macro CORE_ID_EX_FORWARD_EN enables EX/MEM/WB bypass; without it, dependent sources stall.
module core_id_ex
    import core_id_ex_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic        clk,
    input  logic        rst,
    core_id_ex_if.slave bus
);
    logic                  ex_valid_q,    ex_valid_d;
    logic [ALU_CTRL_W-1:0] ex_alu_ctrl_q, ex_alu_ctrl_d;
    logic [XLEN-1:0]       ex_op1_q,      ex_op1_d;
    logic [XLEN-1:0]       ex_op2_q,      ex_op2_d;
    logic [XLEN-1:0]       ex_store_q,    ex_store_d;
    logic [REG_AW-1:0]     ex_rd_addr_q,  ex_rd_addr_d;
    logic                  ex_rd_wen_q,   ex_rd_wen_d;
    logic                  ex_is_load_q,  ex_is_load_d;

    logic [XLEN-1:0] fwd1;
    logic [XLEN-1:0] fwd2;
    logic            stall1;
    logic            stall2;
    logic            hazard;
    logic            pipe_free;

    core_fwd_sel #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs1 (
        .rs_addr_i     (bus.id_rs1_addr),
        .rf_data_i     (bus.id_rs1_data),
        .ex_valid_i    (ex_valid_q),
        .ex_rd_addr_i  (ex_rd_addr_q),
        .ex_rd_wen_i   (ex_rd_wen_q),
        .ex_is_load_i  (ex_is_load_q),
        .ex_result_i   (bus.ex_alu_result),
        .mem_rd_addr_i (bus.mem_rd_addr),
        .mem_rd_wen_i  (bus.mem_rd_wen),
        .mem_result_i  (bus.mem_result),
        .wb_rd_addr_i  (bus.wb_rd_addr),
        .wb_rd_wen_i   (bus.wb_rd_wen),
        .wb_result_i   (bus.wb_result),
        .data_o        (fwd1),
        .stall_o       (stall1)
    );

    core_fwd_sel #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs2 (
        .rs_addr_i     (bus.id_rs2_addr),
        .rf_data_i     (bus.id_rs2_data),
        .ex_valid_i    (ex_valid_q),
        .ex_rd_addr_i  (ex_rd_addr_q),
        .ex_rd_wen_i   (ex_rd_wen_q),
        .ex_is_load_i  (ex_is_load_q),
        .ex_result_i   (bus.ex_alu_result),
        .mem_rd_addr_i (bus.mem_rd_addr),
        .mem_rd_wen_i  (bus.mem_rd_wen),
        .mem_result_i  (bus.mem_result),
        .wb_rd_addr_i  (bus.wb_rd_addr),
        .wb_rd_wen_i   (bus.wb_rd_wen),
        .wb_result_i   (bus.wb_result),
        .data_o        (fwd2),
        .stall_o       (stall2)
    );

    // Only sources the instruction actually reads can create a dependency.
    assign pipe_free    = !ex_valid_q || bus.ex_ready;
    assign hazard       = bus.id_valid && ((bus.id_rs1_used && stall1) || (bus.id_rs2_used && stall2));
    assign bus.id_ready = !rst && pipe_free && !hazard && !bus.flush;

    always_comb begin
        ex_valid_d    = ex_valid_q;
        ex_alu_ctrl_d = ex_alu_ctrl_q;
        ex_op1_d      = ex_op1_q;
        ex_op2_d      = ex_op2_q;
        ex_store_d    = ex_store_q;
        ex_rd_addr_d  = ex_rd_addr_q;
        ex_rd_wen_d   = ex_rd_wen_q;
        ex_is_load_d  = ex_is_load_q;
        if (bus.flush) begin
            ex_valid_d = 1'b0;
        end else if (pipe_free && bus.id_valid && !hazard) begin
            ex_valid_d    = 1'b1;
            ex_alu_ctrl_d = bus.id_alu_ctrl;
            ex_op1_d      = bus.id_use_pc  ? bus.id_pc  : fwd1;
            ex_op2_d      = bus.id_use_imm ? bus.id_imm : fwd2;
            ex_store_d    = fwd2;
            ex_rd_addr_d  = bus.id_rd_addr;
            ex_rd_wen_d   = bus.id_rd_wen;
            ex_is_load_d  = bus.id_is_load;
        end else if (pipe_free) begin
            // Bubble: payload is kept but can no longer match as a writer.
            ex_valid_d  = 1'b0;
            ex_rd_wen_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q    <= 1'b0;
            ex_alu_ctrl_q <= '0;
            ex_op1_q      <= '0;
            ex_op2_q      <= '0;
            ex_store_q    <= '0;
            ex_rd_addr_q  <= '0;
            ex_rd_wen_q   <= 1'b0;
            ex_is_load_q  <= 1'b0;
        end else begin
            ex_valid_q    <= ex_valid_d;
            ex_alu_ctrl_q <= ex_alu_ctrl_d;
            ex_op1_q      <= ex_op1_d;
            ex_op2_q      <= ex_op2_d;
            ex_store_q    <= ex_store_d;
            ex_rd_addr_q  <= ex_rd_addr_d;
            ex_rd_wen_q   <= ex_rd_wen_d;
            ex_is_load_q  <= ex_is_load_d;
        end
    end

    assign bus.ex_valid      = ex_valid_q;
    assign bus.ex_alu_ctrl   = ex_alu_ctrl_q;
    assign bus.ex_oprend_1   = ex_op1_q;
    assign bus.ex_oprend_2   = ex_op2_q;
    assign bus.ex_store_data = ex_store_q;
    assign bus.ex_rd_addr    = ex_rd_addr_q;
    assign bus.ex_rd_wen     = ex_rd_wen_q;
    assign bus.ex_is_load    = ex_is_load_q;

endmodule

// File: tb/tb_core_id_ex.sv
// Bench for core_id_ex: directed vector table for the corner cases, then random cycles
// checked against a writer-list model of operand resolution and hazards.
module tb_core_id_ex;
    import core_id_ex_pkg::*;

`ifdef CORE_ID_EX_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct packed {
        logic        rst;
        logic        flush;
        logic        ex_ready;
        logic        id_valid;
        logic [3:0]  ctrl;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        rs1_used;
        logic        rs2_used;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [4:0]  rd;
        logic        rd_wen;
        logic        is_load;
        logic [31:0] imm;
        logic        use_imm;
        logic [31:0] pc;
        logic        use_pc;
        logic [31:0] ex_result;
        logic [4:0]  mem_rd;
        logic        mem_wen;
        logic [31:0] mem_result;
        logic [4:0]  wb_rd;
        logic        wb_wen;
        logic [31:0] wb_result;
    } stim_t;

    typedef struct packed {
        logic        valid;
        logic [3:0]  ctrl;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] st;
        logic [4:0]  rd;
        logic        wen;
        logic        ld;
    } ex_t;

    typedef struct packed {
        stim_t       s;
        logic        e_ready;
        logic        e_valid;
        logic [31:0] e_op1;
        logic [31:0] e_op2;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_chk = 0;
    int   n_err = 0;
    ex_t  m;
    vec_t tbl[$];

    always #5 clk = ~clk;

    core_id_ex_if bus ();

    core_id_ex dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (vector %0d)", name, act, exp, n_vec);
        end
    endtask

    // Value a source reads: scan producers from youngest to oldest.
    function automatic logic [31:0] resolve(input stim_t s, input logic [4:0] a, input logic [31:0] rf);
        logic        live [3];
        logic [4:0]  dst  [3];
        logic [31:0] val  [3];
        live[0] = m.valid && m.wen && !m.ld; dst[0] = m.rd;     val[0] = s.ex_result;
        live[1] = s.mem_wen;                 dst[1] = s.mem_rd; val[1] = s.mem_result;
        live[2] = s.wb_wen;                  dst[2] = s.wb_rd;  val[2] = s.wb_result;
        if (a == 5'd0) return 32'd0;
        if (FWD) begin
            for (int i = 0; i < 3; i++) begin
                if (live[i] && dst[i] == a) return val[i];
            end
        end
        return rf;
    endfunction

    function automatic logic model_hazard(input stim_t s);
        logic [4:0] pend[$];
        if (m.valid && m.wen && (m.ld || !FWD)) pend.push_back(m.rd);
        if (!FWD && s.mem_wen) pend.push_back(s.mem_rd);
        if (!FWD && s.wb_wen) pend.push_back(s.wb_rd);
        foreach (pend[i]) begin
            if (pend[i] != 5'd0 && ((s.rs1_used && s.rs1 == pend[i]) || (s.rs2_used && s.rs2 == pend[i])))
                return s.id_valid;
        end
        return 1'b0;
    endfunction

    function automatic logic model_ready(input stim_t s);
        return !s.rst && (!m.valid || s.ex_ready) && !model_hazard(s) && !s.flush;
    endfunction

    function automatic ex_t model_next(input stim_t s);
        ex_t  n;
        logic free;
        n    = m;
        free = !m.valid || s.ex_ready;
        if (s.rst) begin
            n = '0;
        end else if (s.flush) begin
            n.valid = 1'b0;
        end else if (free && s.id_valid && !model_hazard(s)) begin
            n.valid = 1'b1;
            n.ctrl  = s.ctrl;
            n.op1   = s.use_pc ? s.pc : resolve(s, s.rs1, s.rs1_data);
            n.op2   = s.use_imm ? s.imm : resolve(s, s.rs2, s.rs2_data);
            n.st    = resolve(s, s.rs2, s.rs2_data);
            n.rd    = s.rd;
            n.wen   = s.rd_wen;
            n.ld    = s.is_load;
        end else if (free) begin
            n.valid = 1'b0;
            n.wen   = 1'b0;
        end
        return n;
    endfunction

    task automatic drive(input stim_t s);
        rst               = s.rst;
        bus.flush         = s.flush;
        bus.ex_ready      = s.ex_ready;
        bus.id_valid      = s.id_valid;
        bus.id_alu_ctrl   = s.ctrl;
        bus.id_rs1_addr   = s.rs1;
        bus.id_rs2_addr   = s.rs2;
        bus.id_rs1_used   = s.rs1_used;
        bus.id_rs2_used   = s.rs2_used;
        bus.id_rs1_data   = s.rs1_data;
        bus.id_rs2_data   = s.rs2_data;
        bus.id_rd_addr    = s.rd;
        bus.id_rd_wen     = s.rd_wen;
        bus.id_is_load    = s.is_load;
        bus.id_imm        = s.imm;
        bus.id_use_imm    = s.use_imm;
        bus.id_pc         = s.pc;
        bus.id_use_pc     = s.use_pc;
        bus.ex_alu_result = s.ex_result;
        bus.mem_rd_addr   = s.mem_rd;
        bus.mem_rd_wen    = s.mem_wen;
        bus.mem_result    = s.mem_result;
        bus.wb_rd_addr    = s.wb_rd;
        bus.wb_rd_wen     = s.wb_wen;
        bus.wb_result     = s.wb_result;
    endtask

    // One clock: drive at negedge, check id_ready mid-cycle, check EX outputs after the edge.
    task automatic run_cycle(input stim_t s, output logic rdy);
        ex_t nx;
        @(negedge clk);
        drive(s);
        #1;
        rdy = bus.id_ready;
        chk("id_ready", 32'(rdy), 32'(model_ready(s)));
        nx = model_next(s);
        @(posedge clk);
        #1;
        m = nx;
        n_vec++;
        chk("ex_valid",      32'(bus.ex_valid),    32'(m.valid));
        chk("ex_alu_ctrl",   32'(bus.ex_alu_ctrl), 32'(m.ctrl));
        chk("ex_oprend_1",   bus.ex_oprend_1,      m.op1);
        chk("ex_oprend_2",   bus.ex_oprend_2,      m.op2);
        chk("ex_store_data", bus.ex_store_data,    m.st);
        chk("ex_rd_addr",    32'(bus.ex_rd_addr),  32'(m.rd));
        chk("ex_rd_wen",     32'(bus.ex_rd_wen),   32'(m.wen));
        chk("ex_is_load",    32'(bus.ex_is_load),  32'(m.ld));
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        s.ex_ready = 1'b1;
        return s;
    endfunction

    function automatic stim_t alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [31:0] d1,
                                  input logic [4:0] rs2, input logic [31:0] d2);
        stim_t s;
        s = idle();
        s.id_valid = 1'b1;
        s.ctrl     = ALU_ADD_OPCODE;
        s.rd       = rd;
        s.rd_wen   = 1'b1;
        s.rs1      = rs1;
        s.rs1_used = 1'b1;
        s.rs1_data = d1;
        s.rs2      = rs2;
        s.rs2_used = 1'b1;
        s.rs2_data = d2;
        return s;
    endfunction

    task automatic push_vec(input stim_t s, input logic r, input logic v, input logic [31:0] o1, input logic [31:0] o2);
        vec_t e;
        e.s = s; e.e_ready = r; e.e_valid = v; e.e_op1 = o1; e.e_op2 = o2;
        tbl.push_back(e);
    endtask

    initial begin
        stim_t s;
        logic  r;
        m = '0;
        s = idle();
        s.rst = 1'b1;
        drive(s);

        // Reset with an instruction waiting.
        s = alu(5'd1, 5'd1, 32'h5, 5'd2, 32'h6); s.rst = 1'b1;
        push_vec(s, 1'b0, 1'b0, 32'h0, 32'h0);
        // WB-only bypass of x5; x0 read as rs2.
        s = alu(5'd1, 5'd5, 32'hDEAD0000, 5'd0, 32'h77);
        s.wb_rd = 5'd5; s.wb_wen = 1'b1; s.wb_result = 32'h10;
        push_vec(s, FWD, FWD, FWD ? 32'h10 : 32'h0, 32'h0);
        push_vec(idle(), 1'b1, 1'b0, FWD ? 32'h10 : 32'h0, 32'h0);
        // EX-to-EX: EX, MEM and WB all write x3, EX must win.
        s = alu(5'd3, 5'd1, 32'h1000, 5'd2, 32'h234);
        push_vec(s, 1'b1, 1'b1, 32'h1000, 32'h234);
        s = alu(5'd4, 5'd3, 32'h1111, 5'd0, 32'h0);
        s.ctrl = ALU_SUB_OPCODE; s.rs2_used = 1'b0; s.use_imm = 1'b1; s.imm = 32'h8;
        s.ex_result = 32'h1234;
        s.mem_rd = 5'd3; s.mem_wen = 1'b1; s.mem_result = 32'h2222;
        s.wb_rd = 5'd3; s.wb_wen = 1'b1; s.wb_result = 32'h3333;
        push_vec(s, FWD, FWD, FWD ? 32'h1234 : 32'h1000, FWD ? 32'h8 : 32'h234);
        // Load-use: one bubble, then the dependent picks up mem_result.
        s = alu(5'd7, 5'd1, 32'h100, 5'd0, 32'h0);
        s.is_load = 1'b1; s.rs2_used = 1'b0; s.use_imm = 1'b1; s.imm = 32'h4;
        push_vec(s, 1'b1, 1'b1, 32'h100, 32'h4);
        s = alu(5'd8, 5'd7, 32'hBAD, 5'd0, 32'h0); s.rs2_used = 1'b0; s.ex_result = 32'h104;
        push_vec(s, 1'b0, 1'b0, 32'h100, 32'h4);
        s.mem_rd = 5'd7; s.mem_wen = 1'b1; s.mem_result = 32'hCAFEF00D;
        push_vec(s, FWD, FWD, FWD ? 32'hCAFEF00D : 32'h100, FWD ? 32'h0 : 32'h4);
        // Backpressure for three cycles, then release.
        s = alu(5'd9, 5'd1, 32'hA, 5'd2, 32'hB);
        push_vec(s, 1'b1, 1'b1, 32'hA, 32'hB);
        s = alu(5'd10, 5'd1, 32'hC, 5'd2, 32'hD); s.ex_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_vec(s, 1'b0, 1'b1, 32'hA, 32'hB);
        s.ex_ready = 1'b1;
        push_vec(s, 1'b1, 1'b1, 32'hC, 32'hD);
        // x0 destination in EX/MEM/WB must never bypass or stall.
        s = alu(5'd0, 5'd1, 32'h1, 5'd2, 32'h2);
        push_vec(s, 1'b1, 1'b1, 32'h1, 32'h2);
        s = alu(5'd11, 5'd0, 32'h55, 5'd0, 32'h66); s.ex_result = 32'hFFFFFFFF;
        s.mem_rd = 5'd0; s.mem_wen = 1'b1; s.mem_result = 32'hFFFFFFFF;
        s.wb_rd = 5'd0; s.wb_wen = 1'b1; s.wb_result = 32'hFFFFFFFF;
        push_vec(s, 1'b1, 1'b1, 32'h0, 32'h0);
        // Flush while EX is stalled by ex_ready=0.
        s = alu(5'd12, 5'd1, 32'h1, 5'd2, 32'h2); s.ex_ready = 1'b0; s.flush = 1'b1;
        push_vec(s, 1'b0, 1'b0, 32'h0, 32'h0);
        push_vec(idle(), 1'b1, 1'b0, 32'h0, 32'h0);
        // Reset in the middle of a load-use stall.
        s = alu(5'd7, 5'd1, 32'h40, 5'd0, 32'h0);
        s.is_load = 1'b1; s.rs2_used = 1'b0; s.use_imm = 1'b1; s.imm = 32'h8;
        push_vec(s, 1'b1, 1'b1, 32'h40, 32'h8);
        s = alu(5'd13, 5'd7, 32'h99, 5'd0, 32'h0); s.rs2_used = 1'b0; s.ex_ready = 1'b0;
        push_vec(s, 1'b0, 1'b1, 32'h40, 32'h8);
        s.rst = 1'b1;
        push_vec(s, 1'b0, 1'b0, 32'h0, 32'h0);
        push_vec(idle(), 1'b1, 1'b0, 32'h0, 32'h0);
        // PC and immediate selection.
        s = alu(5'd14, 5'd1, 32'h3, 5'd2, 32'h0);
        s.use_pc = 1'b1; s.pc = 32'h80000000; s.use_imm = 1'b1; s.imm = 32'h14;
        push_vec(s, 1'b1, 1'b1, 32'h80000000, 32'h14);

        foreach (tbl[i]) begin
            run_cycle(tbl[i].s, r);
            chk($sformatf("tbl%0d id_ready", i), 32'(r), 32'(tbl[i].e_ready));
            chk($sformatf("tbl%0d ex_valid", i), 32'(bus.ex_valid), 32'(tbl[i].e_valid));
            chk($sformatf("tbl%0d ex_oprend_1", i), bus.ex_oprend_1, tbl[i].e_op1);
            chk($sformatf("tbl%0d ex_oprend_2", i), bus.ex_oprend_2, tbl[i].e_op2);
        end

        // Random traffic on a narrow register window so matches are frequent.
        for (int k = 0; k < 3000; k++) begin
            s = '0;
            s.rst        = ($urandom_range(99) == 0);
            s.flush      = ($urandom_range(19) == 0);
            s.ex_ready   = ($urandom_range(3) != 0);
            s.id_valid   = ($urandom_range(3) != 0);
            s.ctrl       = 4'($urandom_range(15));
            s.rs1        = 5'($urandom_range(3));
            s.rs2        = 5'($urandom_range(3));
            s.rs1_used   = 1'($urandom_range(1));
            s.rs2_used   = 1'($urandom_range(1));
            s.rs1_data   = $urandom();
            s.rs2_data   = $urandom();
            s.rd         = 5'($urandom_range(3));
            s.rd_wen     = ($urandom_range(3) != 0);
            s.is_load    = ($urandom_range(2) == 0);
            s.imm        = $urandom();
            s.use_imm    = 1'($urandom_range(1));
            s.pc         = $urandom();
            s.use_pc     = ($urandom_range(3) == 0);
            s.ex_result  = $urandom();
            s.mem_rd     = 5'($urandom_range(3));
            s.mem_wen    = 1'($urandom_range(1));
            s.mem_result = $urandom();
            s.wb_rd      = 5'($urandom_range(3));
            s.wb_wen     = 1'($urandom_range(1));
            s.wb_result  = $urandom();
            run_cycle(s, r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/core_id_ex.md
Name: core_id_ex

Overview:
- ID/EX pipeline stage that sits directly upstream of the execute ALU.
- Resolves source operands from the register file, with bypass from the EX, MEM and WB stages, and applies immediate/PC selection.
- Detects load-use hazards and inserts bubbles.
- Registers alu ctrl, oprend_1 and oprend_2 so the ALU consumes them straight from flops; handles stall and flush with a valid/ready handshake.

Parameters:
- XLEN, 32, datapath width.
- REG_AW, 5, register address width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- id_valid  in  1  decoded instruction present.
- id_ready  out  1  stage accepts the ID instruction this cycle.
- id_alu_ctrl  in  4  ALU opcode (ALU_*_OPCODE encoding).
- id_rs1_addr, id_rs2_addr  in  REG_AW  source registers.
- id_rs1_used, id_rs2_used  in  1  source actually read.
- id_rs1_data, id_rs2_data  in  XLEN  register-file read data.
- id_rd_addr  in  REG_AW  destination register; id_rd_wen  in  1  writes rd.
- id_is_load  in  1  instruction is a load.
- id_imm  in  XLEN  immediate; id_use_imm  in  1  oprend_2 = imm.
- id_pc  in  XLEN  PC; id_use_pc  in  1  oprend_1 = pc.
- flush  in  1  kill the ID instruction and the held EX entry.
- ex_ready  in  1  downstream consumes the EX entry.
- ex_valid  out  1  EX entry valid.
- ex_alu_ctrl  out  4; ex_oprend_1, ex_oprend_2  out  XLEN  to ALU.
- ex_store_data  out  XLEN  resolved rs2.
- ex_rd_addr  out  REG_AW; ex_rd_wen, ex_is_load  out  1.
- ex_alu_result  in  XLEN  ALU output for the current EX entry.
- mem_rd_addr  in  REG_AW; mem_rd_wen  in  1; mem_result  in  XLEN  final MEM-stage value (load data if load).
- wb_rd_addr  in  REG_AW; wb_rd_wen  in  1; wb_result  in  XLEN.

Behaviour:
- Reset: ex_valid=0 and every ex_* output=0; id_ready=0 during reset.
- pipe_free = !ex_valid | ex_ready.
- Source match: addr!=0 & wen & addr==rsN. EX source also requires ex_valid.
- Bypass priority per source:
  - EX match & !ex_is_load -> ex_alu_result;
  - else MEM match -> mem_result;
  - else WB match -> wb_result;
  - else id_rsN_data.
- x0 always resolves to 0.
- hazard = id_valid & ex_valid & ex_is_load & ex_rd_wen & ex_rd_addr!=0 & ((id_rs1_used & ex_rd_addr==id_rs1_addr) | (id_rs2_used & ex_rd_addr==id_rs2_addr)).
- id_ready = pipe_free & !hazard & !flush. Combinational; depends on ex_ready.
- Per-cycle priority:
  1. flush -> ex_valid<=0.
  2. Else pipe_free & id_valid & !hazard -> capture. ex_valid<=1. ex_oprend_1 = id_use_pc ? id_pc : fwd1. ex_oprend_2 = id_use_imm ? id_imm : fwd2. ex_store_data = fwd2. ctrl/rd/wen/is_load copied.
  3. Else pipe_free -> bubble: ex_valid<=0, ex_rd_wen<=0, payload held.
  4. Else (ex_valid & !ex_ready) -> hold all outputs unchanged.
- Latency: 1 cycle from ID acceptance to ex_* valid. Throughput 1/cycle absent hazards.
- Load-use costs exactly one bubble: the load advances to MEM, and the dependent instruction is then bypassed from mem_result.
- Shift amounts pass unmodified; the ALU uses oprend_2[4:0].
- Flush with ex_ready=0 still invalidates the EX entry.
- Reset asserted mid-stall returns to the reset state on the next edge.

Optional Feature:
- Macro CORE_ID_EX_FORWARD_EN.
- Defined: bypass network as above.
- Undefined: no bypass; operands come from id_rsN_data only. hazard extends to any used source matching a pending writer in EX, MEM or WB (same match rule, loads or not), so stalls last until the writer leaves WB.

Decomposition:
- ALU_*_OPCODE and the 4-bit ctrl width stay in the shared INST_OPCODE.v include.
- XLEN/REG_AW defaults are also added there.
- One sub-module: core_fwd_sel (one instance per source) does the match and priority mux, x0 handling included; instantiated twice.

Test Plan:
- WB only: x5 written with wb_result=0x00000010; ID add rs1=x5, rs2=x0 captured -> next cycle ex_oprend_1=0x10, ex_oprend_2=0, ex_valid=1.
- EX-to-EX: EX holds add rd=x3, ex_alu_result=0x1234; ID sub rs1=x3 -> ex_oprend_1=0x1234 captured. With EX, MEM and WB all writing x3, the EX value wins.
- Load-use: EX holds load rd=x7; ID uses x7 -> id_ready=0 for 1 cycle and ex_valid=0 bubble. Next cycle the instruction is captured with mem_result=0xCAFEF00D.
- Backpressure: ex_ready=0 for 3 cycles -> ex_* outputs stable, id_ready=0; ex_ready=1 -> the queued instruction is captured next edge.
- x0 destination: EX entry with rd=x0, wen=1, result 0xFFFFFFFF; ID reads x0 -> oprend_1=0, no stall.
- Flush/reset: flush with ex_valid=1 and ex_ready=0 -> ex_valid=0 next cycle. rst during a hazard stall -> all outputs 0 next edge.
